// File: rtl/conv_stream_engine.sv
// Streaming 1-D convolution core: loads N x samples and M coefficients over
// valid/ready, then emits N-M+1 outputs from a two-stage multiply-accumulate.
module conv_stream_engine #(
  parameter int N  = 112,
  parameter int M  = 49,
  parameter int DW = 10,
  parameter int YW = 26
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic signed [DW-1:0] x_data,
  input  logic                 x_valid,
  output logic                 x_ready,
  input  logic signed [DW-1:0] f_data,
  input  logic                 f_valid,
  output logic                 f_ready,
  output logic signed [YW-1:0] y_data,
  output logic                 y_valid,
  input  logic                 y_ready
);

  localparam int XCW = $clog2(N + 1);
  localparam int FCW = $clog2(M + 1);
  localparam int XIW = (N > 1) ? $clog2(N) : 1;
  localparam int FIW = (M > 1) ? $clog2(M) : 1;

  localparam logic [XCW-1:0] X_FULL = XCW'(N);
  localparam logic [FCW-1:0] F_FULL = FCW'(M);
  localparam logic [XCW-1:0] I_LAST = XCW'(N - M);
  localparam logic [FCW-1:0] J_LAST = FCW'(M - 1);

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    COMPUTE = 2'd1,
    DRAIN   = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic signed [DW-1:0] x_mem [N];
  logic signed [DW-1:0] f_mem [M];

  logic [XCW-1:0] x_cnt_q, x_cnt_d;
  logic [FCW-1:0] f_cnt_q, f_cnt_d;
  logic [XCW-1:0] i_q, i_d;
  logic [FCW-1:0] j_q, j_d;
  logic           x_ready_q, x_ready_d;
  logic           f_ready_q, f_ready_d;

  logic x_fire, f_fire, y_fire;
  logic last_acc, stall, issue;

  logic [XCW-1:0]         x_sum_idx;
  logic [XIW-1:0]         x_rd_idx, x_wr_idx;
  logic [FIW-1:0]         f_rd_idx, f_wr_idx;
  logic signed [DW-1:0]   x_rd, f_rd;

  logic signed [2*DW-1:0] prod_q;
  logic                   p_vld_q, p_first_q, p_last_q;
  logic signed [YW-1:0]   acc_q, acc_sum;
  logic signed [YW-1:0]   y_data_q;
  logic                   y_valid_q;

  assign x_fire = x_valid && x_ready_q;
  assign f_fire = f_valid && f_ready_q;
  assign y_fire = y_valid_q && y_ready;

  // The final tap of an output cannot retire while the output register is
  // full and not draining; the whole MAC freezes until it frees.
  assign last_acc = p_vld_q && p_last_q;
  assign stall    = last_acc && y_valid_q && !y_ready;
  assign issue    = (state_q == COMPUTE) && !stall;

  assign x_sum_idx = i_q + XCW'(j_q);
  assign x_rd_idx  = XIW'(x_sum_idx);
  assign f_rd_idx  = FIW'(j_q);
  assign x_wr_idx  = XIW'(x_cnt_q);
  assign f_wr_idx  = FIW'(f_cnt_q);
  assign x_rd      = x_mem[x_rd_idx];
  assign f_rd      = f_mem[f_rd_idx];

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= LOAD;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_d = state_q;
    unique case (state_q)
      LOAD:    if (x_cnt_q == X_FULL && f_cnt_q == F_FULL) state_d = COMPUTE;
      COMPUTE: if (issue && i_q == I_LAST && j_q == J_LAST) state_d = DRAIN;
      DRAIN:   if (!p_vld_q && y_fire) state_d = LOAD;
      default: state_d = LOAD;
    endcase
  end

  // Output logic: readies are registered and depend only on internal state
  always_comb begin
    x_ready_d = (state_d == LOAD) && (x_cnt_d != X_FULL);
    f_ready_d = (state_d == LOAD) && (f_cnt_d != F_FULL);
  end

  // Load counters and the output/tap iteration indices
  always_comb begin
    x_cnt_d = x_cnt_q;
    f_cnt_d = f_cnt_q;
    i_d     = i_q;
    j_d     = j_q;
    if (x_fire) x_cnt_d = x_cnt_q + XCW'(1);
    if (f_fire) f_cnt_d = f_cnt_q + FCW'(1);
    if (issue) begin
      if (j_q == J_LAST) begin
        j_d = '0;
        i_d = (i_q == I_LAST) ? '0 : i_q + XCW'(1);
      end else begin
        j_d = j_q + FCW'(1);
      end
    end
    if (state_q == DRAIN && state_d == LOAD) begin
      x_cnt_d = '0;
      f_cnt_d = '0;
    end
  end

  assign acc_sum = (p_first_q ? '0 : acc_q) + YW'(prod_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      x_cnt_q   <= '0;
      f_cnt_q   <= '0;
      i_q       <= '0;
      j_q       <= '0;
      x_ready_q <= 1'b0;
      f_ready_q <= 1'b0;
      prod_q    <= '0;
      p_vld_q   <= 1'b0;
      p_first_q <= 1'b0;
      p_last_q  <= 1'b0;
      acc_q     <= '0;
      y_data_q  <= '0;
      y_valid_q <= 1'b0;
    end else begin
      x_cnt_q   <= x_cnt_d;
      f_cnt_q   <= f_cnt_d;
      i_q       <= i_d;
      j_q       <= j_d;
      x_ready_q <= x_ready_d;
      f_ready_q <= f_ready_d;
      if (!stall) begin
        p_vld_q   <= issue;
        p_first_q <= issue && (j_q == '0);
        p_last_q  <= issue && (j_q == J_LAST);
        if (issue)   prod_q <= (2*DW)'(x_rd) * (2*DW)'(f_rd);
        if (p_vld_q) acc_q  <= acc_sum;
      end
      if (last_acc && !stall) begin
        y_data_q  <= acc_sum;
        y_valid_q <= 1'b1;
      end else if (y_fire) begin
        y_valid_q <= 1'b0;
      end
    end
  end

  // NOTE: sample memories carry no reset; each entry is rewritten in LOAD before COMPUTE reads it.
  always_ff @(posedge clk) begin
    if (x_fire) x_mem[x_wr_idx] <= x_data;
    if (f_fire) f_mem[f_wr_idx] <= f_data;
  end

  assign x_ready = x_ready_q;
  assign f_ready = f_ready_q;
  assign y_data  = y_data_q;
  assign y_valid = y_valid_q;

endmodule

// File: tb/tb_conv_stream_engine.sv
// Directed bench for conv_stream_engine: four instances (8/3, 112/49, 4/4, 4/1)
// share stimulus through a select, and each scenario task checks its own results.
module tb_conv_stream_engine;

  localparam int DW = 10;
  localparam int YW = 26;
  localparam int NI = 4;
  localparam int LOAD_BUDGET = 2000;
  localparam int COLLECT_BUDGET = 10000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   sel = 0;

  logic signed [DW-1:0] x_data, f_data;
  logic x_valid = 1'b0, f_valid = 1'b0, y_ready = 1'b0;

  logic xv [NI], fv [NI], yr [NI];
  logic xr [NI], fr [NI], yv [NI];
  logic signed [YW-1:0] yd [NI];

  logic xr_m, fr_m, yv_m;
  logic signed [YW-1:0] yd_m;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  always_comb begin
    for (int k = 0; k < NI; k++) begin
      xv[k] = x_valid && (sel == k);
      fv[k] = f_valid && (sel == k);
      yr[k] = y_ready && (sel == k);
    end
    xr_m = xr[sel];
    fr_m = fr[sel];
    yv_m = yv[sel];
    yd_m = yd[sel];
  end

  conv_stream_engine #(.N(8), .M(3), .DW(DW), .YW(YW)) u_small (
    .clk(clk), .reset(reset),
    .x_data(x_data), .x_valid(xv[0]), .x_ready(xr[0]),
    .f_data(f_data), .f_valid(fv[0]), .f_ready(fr[0]),
    .y_data(yd[0]), .y_valid(yv[0]), .y_ready(yr[0]));

  conv_stream_engine #(.N(112), .M(49), .DW(DW), .YW(YW)) u_full (
    .clk(clk), .reset(reset),
    .x_data(x_data), .x_valid(xv[1]), .x_ready(xr[1]),
    .f_data(f_data), .f_valid(fv[1]), .f_ready(fr[1]),
    .y_data(yd[1]), .y_valid(yv[1]), .y_ready(yr[1]));

  conv_stream_engine #(.N(4), .M(4), .DW(DW), .YW(YW)) u_eq (
    .clk(clk), .reset(reset),
    .x_data(x_data), .x_valid(xv[2]), .x_ready(xr[2]),
    .f_data(f_data), .f_valid(fv[2]), .f_ready(fr[2]),
    .y_data(yd[2]), .y_valid(yv[2]), .y_ready(yr[2]));

  conv_stream_engine #(.N(4), .M(1), .DW(DW), .YW(YW)) u_one (
    .clk(clk), .reset(reset),
    .x_data(x_data), .x_valid(xv[3]), .x_ready(xr[3]),
    .f_data(f_data), .f_valid(fv[3]), .f_ready(fr[3]),
    .y_data(yd[3]), .y_valid(yv[3]), .y_ready(yr[3]));

  // All tasks start and end 1 time unit after a rising edge.
  task automatic load(input int xs[$], input int fs[$], input bit gaps,
                      output bit ok, output int y_seen);
    int xi = 0;
    int fi = 0;
    int cyc = 0;
    bit tx, tf;
    y_seen = 0;
    while ((xi < xs.size() || fi < fs.size()) && cyc < LOAD_BUDGET) begin
      x_valid = (xi < xs.size()) && (!gaps || $urandom_range(0, 1) == 1);
      f_valid = (fi < fs.size()) && (!gaps || $urandom_range(0, 1) == 1);
      x_data  = 'x;
      f_data  = 'x;
      if (x_valid) x_data = DW'(xs[xi]);
      if (f_valid) f_data = DW'(fs[fi]);
      tx = x_valid && xr_m;
      tf = f_valid && fr_m;
      if (yv_m) y_seen++;
      @(posedge clk); #1;
      cyc++;
      if (tx) xi++;
      if (tf) fi++;
    end
    x_valid = 1'b0;
    f_valid = 1'b0;
    x_data  = 'x;
    f_data  = 'x;
    ok = (cyc < LOAD_BUDGET);
  endtask

  task automatic collect(input int cnt, input bit rnd, input int hold,
                         output int got[$], output int unstable);
    int cyc = 0;
    int held = 0;
    bit seen = 0;
    logic signed [YW-1:0] first_val = '0;
    got.delete();
    unstable = 0;
    while (got.size() < cnt && cyc < COLLECT_BUDGET) begin
      if (yv_m && !seen) begin
        seen = 1;
        first_val = yd_m;
      end
      if (seen && held < hold) begin
        y_ready = 1'b0;
        held++;
        if (yd_m !== first_val || yv_m !== 1'b1) unstable++;
      end else begin
        y_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      if (yv_m && y_ready) got.push_back(int'(yd_m));
      @(posedge clk); #1;
      cyc++;
    end
    y_ready = 1'b0;
  endtask

  function automatic void conv_model(input int xs[$], input int fs[$], output int ys[$]);
    int acc;
    ys.delete();
    for (int i = 0; i + fs.size() <= xs.size(); i++) begin
      acc = 0;
      for (int j = 0; j < fs.size(); j++) acc += xs[i + j] * fs[j];
      ys.push_back(acc);
    end
  endfunction

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < NI; k++) begin
      n_checks++;
      if ({xr[k], fr[k], yv[k]} !== 3'b000 || yd[k] !== '0) begin
        n_fail++;
        $display("FAIL reset_state[%0d]: xr/fr/yv=%b%b%b y=%0d, required 000 y=0",
                 k, xr[k], fr[k], yv[k], yd[k]);
      end
    end
    reset = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k < NI; k++) begin
      n_checks++;
      if ({xr[k], fr[k]} !== 2'b11) begin
        n_fail++;
        $display("FAIL ready_after_reset[%0d]: xr/fr=%b%b, required 11", k, xr[k], fr[k]);
      end
    end
  endtask

  task automatic test_basic(input string name, input int f0, input int f1, input int f2,
                            input int y0, input int ystep);
    int xs[$], fs[$], got[$];
    int y_seen, unst;
    bit ok;
    sel = 0;
    for (int i = 1; i <= 8; i++) xs.push_back(i);
    fs.push_back(f0); fs.push_back(f1); fs.push_back(f2);
    load(xs, fs, 1'b0, ok, y_seen);
    n_checks++;
    if (ok !== 1'b1 || {xr_m, fr_m} !== 2'b00) begin
      n_fail++;
      $display("FAIL %s_load: done=%b xr/fr=%b%b, required done=1 xr/fr=00", name, ok, xr_m, fr_m);
    end
    collect(6, 1'b0, 0, got, unst);
    n_checks++;
    if (got.size() !== 6) begin
      n_fail++;
      $display("FAIL %s_count: got %0d outputs, required 6", name, got.size());
    end
    foreach (got[i]) begin
      n_checks++;
      if (got[i] !== y0 + ystep * i) begin
        n_fail++;
        $display("FAIL %s_y[%0d]: got %0d, required %0d", name, i, got[i], y0 + ystep * i);
      end
    end
    n_checks++;
    if ({xr_m, fr_m, yv_m} !== 3'b110) begin
      n_fail++;
      $display("FAIL %s_next_iter: xr/fr/yv=%b%b%b, required 110", name, xr_m, fr_m, yv_m);
    end
  endtask

  task automatic test_full_scale(input int fval, input int yexp);
    int xs[$], fs[$], got[$];
    int y_seen, unst, bad;
    bit ok;
    sel = 1;
    repeat (112) xs.push_back(-512);
    repeat (49) fs.push_back(fval);
    load(xs, fs, 1'b0, ok, y_seen);
    collect(64, 1'b0, 0, got, unst);
    n_checks++;
    if (ok !== 1'b1 || got.size() !== 64) begin
      n_fail++;
      $display("FAIL full_count_f%0d: loaded=%b outputs=%0d, required 1 and 64", fval, ok, got.size());
    end
    bad = 0;
    foreach (got[i]) begin
      n_checks++;
      if (got[i] !== yexp) begin
        n_fail++;
        bad++;
        if (bad < 4) $display("FAIL full_y_f%0d[%0d]: got %0d, required %0d", fval, i, got[i], yexp);
      end
    end
  endtask

  task automatic test_boundary();
    int xs[$], fs[$], got[$], exp[$];
    int y_seen, unst;
    bit ok;
    // N == M: one output; last x and last f arrive on the same edge.
    sel = 2;
    xs.push_back(1); xs.push_back(-2); xs.push_back(3); xs.push_back(-4);
    fs.push_back(5); fs.push_back(6); fs.push_back(-7); fs.push_back(8);
    load(xs, fs, 1'b0, ok, y_seen);
    collect(1, 1'b0, 0, got, unst);
    n_checks++;
    if (got.size() !== 1 || got[0] !== -60) begin
      n_fail++;
      $display("FAIL eq_nm_y: got %0d outputs first=%0d, required 1 output -60",
               got.size(), (got.size() > 0) ? got[0] : 0);
    end
    n_checks++;
    if ({xr_m, fr_m, yv_m} !== 3'b110) begin
      n_fail++;
      $display("FAIL eq_nm_next_iter: xr/fr/yv=%b%b%b, required 110", xr_m, fr_m, yv_m);
    end
    // M == 1: plain scaling.
    sel = 3;
    xs.delete(); fs.delete();
    xs.push_back(3); xs.push_back(-5); xs.push_back(7); xs.push_back(-9);
    fs.push_back(-6);
    exp.push_back(-18); exp.push_back(30); exp.push_back(-42); exp.push_back(54);
    load(xs, fs, 1'b0, ok, y_seen);
    collect(4, 1'b0, 0, got, unst);
    n_checks++;
    if (got.size() !== 4) begin
      n_fail++;
      $display("FAIL m1_count: got %0d outputs, required 4", got.size());
    end
    foreach (got[i]) begin
      n_checks++;
      if (got[i] !== exp[i]) begin
        n_fail++;
        $display("FAIL m1_y[%0d]: got %0d, required %0d", i, got[i], exp[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    int xs[$], fs[$], got[$];
    int y_seen, unst;
    bit ok;
    sel = 0;
    for (int i = 1; i <= 8; i++) xs.push_back(i);
    repeat (3) fs.push_back(1);
    load(xs, fs, 1'b0, ok, y_seen);
    collect(6, 1'b0, 100, got, unst);
    n_checks++;
    if (unst !== 0) begin
      n_fail++;
      $display("FAIL hold_stable: %0d unstable cycles, required 0", unst);
    end
    n_checks++;
    if (got.size() !== 6) begin
      n_fail++;
      $display("FAIL hold_count: got %0d outputs, required 6", got.size());
    end
    foreach (got[i]) begin
      n_checks++;
      if (got[i] !== 6 + 3 * i) begin
        n_fail++;
        $display("FAIL hold_y[%0d]: got %0d, required %0d", i, got[i], 6 + 3 * i);
      end
    end
  endtask

  task automatic test_random_stalls();
    int xs[$], fs[$], got[$], exp[$];
    int y_seen, unst, bad;
    bit ok;
    sel = 0;
    bad = 0;
    for (int it = 0; it < 20; it++) begin
      xs.delete(); fs.delete();
      repeat (8) xs.push_back(int'($urandom_range(0, 1023)) - 512);
      repeat (3) fs.push_back(int'($urandom_range(0, 1023)) - 512);
      conv_model(xs, fs, exp);
      load(xs, fs, 1'b1, ok, y_seen);
      collect(6, 1'b1, 0, got, unst);
      n_checks++;
      if (ok !== 1'b1 || got.size() !== 6 || y_seen !== 0) begin
        n_fail++;
        $display("FAIL rand_iter%0d: loaded=%b outputs=%0d early_y=%0d, required 1/6/0",
                 it, ok, got.size(), y_seen);
      end
      foreach (got[i]) begin
        n_checks++;
        if (got[i] !== exp[i]) begin
          n_fail++;
          bad++;
          if (bad < 6) $display("FAIL rand_y[%0d][%0d]: got %0d, required %0d", it, i, got[i], exp[i]);
        end
      end
    end
  endtask

  task automatic test_reset_midway();
    int xs[$], fs[$], got[$];
    int y_seen, unst;
    bit ok;
    sel = 0;
    for (int i = 1; i <= 8; i++) xs.push_back(i);
    repeat (3) fs.push_back(1);
    load(xs, fs, 1'b0, ok, y_seen);
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (yv_m !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_pre_reset: y_valid=%b, required 0", yv_m);
    end
    y_ready = 1'b1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    y_ready = 1'b0;
    n_checks++;
    if ({xr_m, fr_m, yv_m} !== 3'b000) begin
      n_fail++;
      $display("FAIL abort_in_reset: xr/fr/yv=%b%b%b, required 000", xr_m, fr_m, yv_m);
    end
    @(posedge clk); #1;
    n_checks++;
    if ({xr_m, fr_m, yv_m} !== 3'b110) begin
      n_fail++;
      $display("FAIL abort_restart: xr/fr/yv=%b%b%b, required 110", xr_m, fr_m, yv_m);
    end
    xs.delete();
    for (int i = 8; i >= 1; i--) xs.push_back(i);
    load(xs, fs, 1'b0, ok, y_seen);
    n_checks++;
    if (y_seen !== 0) begin
      n_fail++;
      $display("FAIL abort_stale_y: %0d y_valid cycles during reload, required 0", y_seen);
    end
    collect(6, 1'b0, 0, got, unst);
    n_checks++;
    if (got.size() !== 6) begin
      n_fail++;
      $display("FAIL abort_count: got %0d outputs, required 6", got.size());
    end
    foreach (got[i]) begin
      n_checks++;
      if (got[i] !== 21 - 3 * i) begin
        n_fail++;
        $display("FAIL abort_y[%0d]: got %0d, required %0d", i, got[i], 21 - 3 * i);
      end
    end
  endtask

  initial begin
    x_data = 'x;
    f_data = 'x;
    test_reset();
    test_basic("ones", 1, 1, 1, 6, 3);
    test_basic("signed", 2, 0, -1, -1, 1);
    test_full_scale(-512, 12845056);
    test_full_scale(511, -12819968);
    test_boundary();
    test_backpressure();
    test_random_stalls();
    test_reset_midway();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
